// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen
//   Raster timing generator for VGA/LCD sinks with a built-in test-pattern
//   source. Two counters (h, v) sweep the blanking-inclusive raster; every
//   output is registered from the counter value of the previous cycle.
//
// Ports
//   pixel_clk      pixel clock, all logic on its rising edge
//   pixel_rst      synchronous reset, active-high
//   mode_i         pattern select: 0 black, 1 colour bars, 2 grid, 3 external
//   ext_rgb_i      external pixel {R,G,B}, sampled the edge after ext_req_o
//   ext_req_o      request for the pixel shown on pix_x_o/pix_y_o next cycle
//   hs_o, vs_o     sync outputs, active level HS_POL / VS_POL
//   de_o           data enable, high in the active area
//   pix_x_o/_y_o   coordinates of the pixel currently presented
//   rgb_o          pixel colour {R[7:0],G[7:0],B[7:0]}, zero outside active
//   frame_start_o  one-cycle pulse together with pixel (0,0)
//   frame_cnt_o    frames started since reset, wraps at 2^16
module vga_timing_pattern_gen #(
    parameter int unsigned HDISP  = 800,
    parameter int unsigned VDISP  = 480,
    parameter int unsigned HFP    = 40,
    parameter int unsigned HPULSE = 48,
    parameter int unsigned HBP    = 40,
    parameter int unsigned VFP    = 12,
    parameter int unsigned VPULSE = 3,
    parameter int unsigned VBP    = 40,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0,
    localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP,
    localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP,
    localparam int unsigned HW     = $clog2(HTOTAL),
    localparam int unsigned VW     = $clog2(VTOTAL)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic [1:0]    mode_i,
    input  logic [23:0]   ext_rgb_i,
    output logic          ext_req_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          de_o,
    output logic [HW-1:0] pix_x_o,
    output logic [VW-1:0] pix_y_o,
    output logic [23:0]   rgb_o,
    output logic          frame_start_o,
    output logic [15:0]   frame_cnt_o
);

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_EXT   = 2'd3
    } mode_e;

    localparam logic [HW-1:0] H_LAST       = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_DISP       = HW'(HDISP);
    localparam logic [HW-1:0] H_DISP_LAST  = HW'(HDISP - 1);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(HDISP + HFP + HPULSE - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_DISP       = VW'(VDISP);
    localparam logic [VW-1:0] V_DISP_LAST  = VW'(VDISP - 1);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(VDISP + VFP + VPULSE - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    mode_e         mode_q, mode_d;
    logic          started_q, started_d;
    logic          ext_req_q, ext_req_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [HW-1:0] pix_x_q, pix_x_d;
    logic [VW-1:0] pix_y_q, pix_y_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic          h_end;
    logic          v_end;
    logic          origin;
    logic          active;
    logic          grid_line;
    logic [2:0]    bar;

    always_comb begin
        h_end  = (h_q == H_LAST);
        v_end  = (v_q == V_LAST);
        origin = (h_q == '0) && (v_q == '0);
        active = (h_q < H_DISP) && (v_q < V_DISP);

        h_d = h_end ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_end) begin
            v_d = v_end ? '0 : v_q + 1'b1;
        end

        // Shadow mode only changes on the last raster position, so the new
        // pattern starts exactly with the next frame's pixel (0,0).
        mode_d = (h_end && v_end) ? mode_e'(mode_i) : mode_q;

        // Request is registered from the next counter value, so it is high in
        // the same cycle the counter sits on an active pixel.
        ext_req_d = (mode_d == MODE_EXT) && (h_d < H_DISP) && (v_d < V_DISP);

        hs_d = (h_q >= H_SYNC_FIRST && h_q <= H_SYNC_LAST) ? HS_POL : ~HS_POL;
        vs_d = (v_q >= V_SYNC_FIRST && v_q <= V_SYNC_LAST) ? VS_POL : ~VS_POL;
        de_d          = active;
        pix_x_d       = h_q;
        pix_y_d       = v_q;
        frame_start_d = origin;

        // The first frame after reset reports 0; each later frame start adds 1.
        started_d   = started_q | origin;
        frame_cnt_d = frame_cnt_q;
        if (origin) begin
            frame_cnt_d = frame_cnt_q + 16'(started_q);
        end

        // Bar index = floor(x*8/HDISP), found by comparing against boundaries.
        bar = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if ({h_q, 3'b000} >= (HW + 3)'(k * HDISP)) begin
                bar = 3'(k);
            end
        end

        grid_line = (h_q[3:0] == 4'h0) || (v_q[3:0] == 4'h0) ||
                    (h_q == H_DISP_LAST) || (v_q == V_DISP_LAST);

        rgb_d = '0;
        if (active) begin
            unique case (mode_q)
                MODE_BLACK: rgb_d = '0;
                // Bar order white..black maps to R=~b[1], G=~b[2], B=~b[0].
                MODE_BARS:  rgb_d = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
                MODE_GRID:  rgb_d = grid_line ? '1 : '0;
                MODE_EXT:   rgb_d = ext_rgb_i;
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            h_q           <= '0;
            v_q           <= '0;
            mode_q        <= MODE_BLACK;
            started_q     <= 1'b0;
            ext_req_q     <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            de_q          <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            mode_q        <= mode_d;
            started_q     <= started_d;
            ext_req_q     <= ext_req_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign ext_req_o     = ext_req_q;
    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign de_o          = de_q;
    assign pix_x_o       = pix_x_q;
    assign pix_y_o       = pix_y_q;
    assign rgb_o         = rgb_q;
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Testbench for vga_timing_pattern_gen with a reduced raster so several whole
// frames fit in a short run. Expected outputs come from the raster position
// derived arithmetically from the number of clock edges since reset release.
module tb_vga_timing_pattern_gen;

    localparam int unsigned HD = 32;
    localparam int unsigned VD = 20;
    localparam int unsigned HF = 4;
    localparam int unsigned HP = 6;
    localparam int unsigned HB = 5;
    localparam int unsigned VF = 2;
    localparam int unsigned VP = 3;
    localparam int unsigned VB = 4;
    localparam int unsigned HT = HD + HF + HP + HB;
    localparam int unsigned VT = VD + VF + VP + VB;
    localparam int unsigned FR = HT * VT;
    localparam int unsigned HWB = $clog2(HT);
    localparam int unsigned VWB = $clog2(VT);
    localparam int unsigned MAXF = 32;

    logic           pixel_clk = 1'b0;
    logic           pixel_rst = 1'b1;
    logic [1:0]     mode_i    = 2'd0;
    logic [23:0]    ext_rgb_i = '0;
    logic           ext_req_o;
    logic           hs_o;
    logic           vs_o;
    logic           de_o;
    logic [HWB-1:0] pix_x_o;
    logic [VWB-1:0] pix_y_o;
    logic [23:0]    rgb_o;
    logic           frame_start_o;
    logic [15:0]    frame_cnt_o;

    vga_timing_pattern_gen #(
        .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
        .VFP(VF), .VPULSE(VP), .VBP(VB), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .pixel_clk(pixel_clk),
        .pixel_rst(pixel_rst),
        .mode_i(mode_i),
        .ext_rgb_i(ext_rgb_i),
        .ext_req_o(ext_req_o),
        .hs_o(hs_o),
        .vs_o(vs_o),
        .de_o(de_o),
        .pix_x_o(pix_x_o),
        .pix_y_o(pix_y_o),
        .rgb_o(rgb_o),
        .frame_start_o(frame_start_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 pixel_clk = ~pixel_clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned j     = 0;          // rising edges since reset release
    int unsigned frame_mode [MAXF];  // pattern mode of each frame since reset
    logic [23:0] bar_colour [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s pos=%0d observed=0x%0h expected=0x%0h", tag, j, obs, exp);
        end
    endtask

    function automatic bit pos_active(input int unsigned p);
        int unsigned x = p % HT;
        int unsigned y = (p / HT) % VT;
        return (x < HD) && (y < VD);
    endfunction

    function automatic int unsigned mode_at(input int unsigned p);
        int unsigned f = p / FR;
        return (f < MAXF) ? frame_mode[f] : 0;
    endfunction

    function automatic logic [23:0] ext_word(input int unsigned p);
        int unsigned x = p % HT;
        int unsigned y = (p / HT) % VT;
        return {8'(x), 8'(y), 8'hA5};
    endfunction

    function automatic logic [23:0] pattern(input int unsigned p);
        int unsigned x = p % HT;
        int unsigned y = (p / HT) % VT;
        if (!pos_active(p)) return 24'h0;
        case (mode_at(p))
            1: return bar_colour[(x * 8) / HD];
            2: return ((x % 16 == 0) || (y % 16 == 0) || (x == HD - 1) || (y == VD - 1))
                      ? 24'hFFFFFF : 24'h000000;
            3: return ext_word(p);
            default: return 24'h0;
        endcase
    endfunction

    // One clock edge: drive upstream data, then check the outputs for the
    // raster position the counter held before this edge.
    task automatic step();
        int unsigned p = j;
        int unsigned x;
        int unsigned y;
        bit          act;
        ext_rgb_i = (pos_active(p) && mode_at(p) == 3) ? ext_word(p) : 24'($urandom);
        if ((p % FR == FR - 1) && (p / FR + 1 < MAXF)) frame_mode[p / FR + 1] = int'(mode_i);
        @(posedge pixel_clk);
        #1;
        j++;
        x   = p % HT;
        y   = (p / HT) % VT;
        act = pos_active(p);
        check("de", 32'(de_o), 32'(act));
        check("hs", 32'(hs_o), (x >= HD + HF && x < HD + HF + HP) ? 32'd0 : 32'd1);
        check("vs", 32'(vs_o), (y >= VD + VF && y < VD + VF + VP) ? 32'd0 : 32'd1);
        check("frame_start", 32'(frame_start_o), (x == 0 && y == 0) ? 32'd1 : 32'd0);
        check("frame_cnt", 32'(frame_cnt_o), (p / FR) & 32'hFFFF);
        check("rgb", 32'(rgb_o), 32'(pattern(p)));
        check("ext_req", 32'(ext_req_o), (pos_active(j) && mode_at(j) == 3) ? 32'd1 : 32'd0);
        if (act) begin
            check("pix_x", 32'(pix_x_o), x);
            check("pix_y", 32'(pix_y_o), y);
        end
    endtask

    task automatic do_reset(input int unsigned cycles);
        pixel_rst = 1'b1;
        mode_i    = 2'd3;
        for (int unsigned i = 0; i < cycles; i++) begin
            ext_rgb_i = 24'($urandom);
            @(posedge pixel_clk);
            #1;
            check("rst_de", 32'(de_o), 32'd0);
            check("rst_rgb", 32'(rgb_o), 32'd0);
            check("rst_pix_x", 32'(pix_x_o), 32'd0);
            check("rst_pix_y", 32'(pix_y_o), 32'd0);
            check("rst_ext_req", 32'(ext_req_o), 32'd0);
            check("rst_frame_start", 32'(frame_start_o), 32'd0);
            check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
            check("rst_hs", 32'(hs_o), 32'd1);
            check("rst_vs", 32'(vs_o), 32'd1);
        end
        pixel_rst = 1'b0;
        j = 0;
        for (int unsigned f = 0; f < MAXF; f++) frame_mode[f] = 0;
    endtask

    // Finish the current frame; mode_i gets a throw-away value early in the
    // frame and the target for the next frame later on.
    task automatic run_frame(input logic [1:0] target);
        int unsigned start_f = j / FR;
        int unsigned a = $urandom_range(0, FR / 2 - 1);
        int unsigned b = $urandom_range(FR / 2, FR - 2);
        while (j / FR == start_f) begin
            if (j % FR == a) mode_i = 2'($urandom_range(0, 3));
            if (j % FR == b) mode_i = target;
            step();
        end
    endtask

    task automatic run_until(input int unsigned pos);
        while (j % FR != pos) step();
    endtask

    initial begin
        do_reset(5);
        run_frame(2'd1);
        run_frame(2'd2);
        run_frame(2'd3);
        run_frame(2'd0);
        run_frame(2'd3);
        run_frame(2'd1);
        mode_i = 2'd3;
        run_until(200 % VT * HT + 20);
        do_reset(1);
        run_frame(2'd2);
        run_frame(2'd3);
        run_frame(2'd1);
        run_frame(2'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
